// File: rtl/if_fetch_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_pkg
//   Shared definitions for the instruction-fetch stage: bus widths, the zero
//   word, the NOP instruction and the fetch FSM state encodings.
// -----------------------------------------------------------------------------
package if_fetch_pkg;

    localparam int INST_ADDR_W = 32;   // InstAddrBus width
    localparam int INST_W      = 32;   // InstBus width

    localparam logic [INST_ADDR_W-1:0] ZERO_WORD = '0;
    localparam logic [INST_W-1:0]      NOP_WORD  = 32'h0000_0013;  // addi x0,x0,0

    // S_REQ  : request being issued / outstanding
    // S_FULL : hold buffer occupied, no request on the bus
    // S_DROP : waiting for the ack of a request aborted by a redirect
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_FULL = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    // Force a byte address onto a word boundary.
    function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] a);
        return {a[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_hold_buf.sv
// -----------------------------------------------------------------------------
// if_hold_buf
//   One-entry pc/inst holding register. Catches an instruction acked while the
//   pipeline is stalled so it is not lost.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     load_i          capture pc_i/inst_i and mark the entry valid
//     clear_i         invalidate the entry (wins over load_i)
//     pc_i, inst_i    entry to capture
//     valid_o         entry holds data
//     pc_o, inst_o    stored entry
// -----------------------------------------------------------------------------
module if_hold_buf
    import if_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic                   clear_i,
    input  logic [INST_ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0]      inst_i,
    output logic                   valid_o,
    output logic [INST_ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0]      inst_o
);

    logic                   valid_q, valid_d;
    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0]      inst_q, inst_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            inst_d  = inst_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) valid_q <= 1'b0;
        else     valid_q <= valid_d;
    end

    // NOTE: the payload is not reset; it is only ever observed while valid_q=1.
    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        inst_q <= inst_d;
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
//   Instruction-fetch stage. Owns the fetch PC, reads one word at a time over a
//   req/ack memory interface and presents one registered pc/inst pair per cycle
//   to decode. Handles decode stalls (via a 1-entry hold buffer) and EX
//   redirects (discarding any wrong-path response still in flight).
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     stall_i           hold the downstream outputs
//     branch_enable_i   redirect fetch to branch_target_i (word aligned)
//     mem_req_o         read request, mem_addr_o stable until mem_ack_i
//     mem_ack_i         read completes this cycle, mem_rdata_i valid
//     pc_o/inst_o       instruction to decode and its PC
//     inst_valid_o      inst_o is a real on-path instruction
// -----------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = ZERO_WORD,
    parameter logic [INST_W-1:0]      NOP_INST = NOP_WORD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   branch_enable_i,
    input  logic [INST_ADDR_W-1:0] branch_target_i,
    output logic                   mem_req_o,
    output logic [INST_ADDR_W-1:0] mem_addr_o,
    input  logic                   mem_ack_i,
    input  logic [INST_W-1:0]      mem_rdata_i,
    output logic [INST_ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0]      inst_o,
    output logic                   inst_valid_o
);

    fetch_state_e           state_q, state_d;
    logic [INST_ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [INST_ADDR_W-1:0] drop_addr_q, drop_addr_d;   // address of the aborted request
    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0]      inst_q, inst_d;
    logic                   valid_q, valid_d;

    logic                   buf_load, buf_clear, buf_valid;
    logic [INST_ADDR_W-1:0] buf_pc;
    logic [INST_W-1:0]      buf_inst;

    if_hold_buf u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .pc_i    (fetch_pc_q),
        .inst_i  (mem_rdata_i),
        .valid_o (buf_valid),
        .pc_o    (buf_pc),
        .inst_o  (buf_inst)
    );

    // NOTE: every signal assigned below gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        valid_d     = valid_q;
        buf_load    = 1'b0;
        buf_clear   = 1'b0;

        if (branch_enable_i) begin
            // Redirect beats stall and any same-cycle ack; pc_o keeps its value.
            fetch_pc_d = word_align(branch_target_i);
            buf_clear  = 1'b1;
            valid_d    = 1'b0;
            inst_d     = NOP_INST;
            unique case (state_q)
                S_REQ: begin
                    if (!mem_ack_i) begin
                        // Bus address must not move mid-transaction: park it.
                        state_d     = S_DROP;
                        drop_addr_d = fetch_pc_q;
                    end
                end
                S_DROP:  state_d = mem_ack_i ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (mem_ack_i) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if (stall_i) begin
                            buf_load = 1'b1;
                            state_d  = S_FULL;
                        end else begin
                            pc_d    = fetch_pc_q;
                            inst_d  = mem_rdata_i;
                            valid_d = 1'b1;
                        end
                    end else if (!stall_i) begin
                        valid_d = 1'b0;
                        inst_d  = NOP_INST;
                    end
                end
                S_FULL: begin
                    if (!stall_i) begin
                        pc_d      = buf_pc;
                        inst_d    = buf_valid ? buf_inst : NOP_INST;
                        valid_d   = buf_valid;
                        buf_clear = 1'b1;
                        state_d   = S_REQ;
                    end
                end
                S_DROP: begin
                    // The ack that ends this state carries wrong-path data.
                    if (mem_ack_i) state_d = S_REQ;
                    if (!stall_i) begin
                        valid_d = 1'b0;
                        inst_d  = NOP_INST;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= RESET_PC;
            pc_q        <= ZERO_WORD;
            inst_q      <= NOP_INST;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            valid_q     <= valid_d;
        end
    end

    assign mem_req_o    = ~rst & (state_q != S_FULL);
    assign mem_addr_o   = (state_q == S_DROP) ? drop_addr_q : fetch_pc_q;
    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage; produces the pc/inst pair consumed by the decode stage.
- Owns the fetch PC, issues word reads over a req/ack instruction-memory interface and presents one registered instruction per cycle downstream.
- Honours a pipeline stall from control and a branch/jump redirect from EX, discarding any wrong-path response still in flight.
- Contains a 1-entry hold buffer so an ack arriving during a stall is never lost.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0).
- NOP_INST, 32'h0000_0013, instruction driven on inst_o when no valid instruction (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- stall_i  in  1  hold downstream outputs (decode/control stall)
- branch_enable_i  in  1  redirect fetch (taken branch/JAL/JALR from EX)
- branch_target_i  in  32  redirect address
- mem_req_o  out  1  instruction read request
- mem_addr_o  out  32  read word address, stable while mem_req_o=1 and no ack
- mem_ack_i  in  1  read completes this cycle; may coincide with the first req cycle
- mem_rdata_i  in  32  instruction data, valid when mem_ack_i=1
- pc_o  out  32  PC of inst_o
- inst_o  out  32  instruction to decode
- inst_valid_o  out  1  inst_o is a real, on-path instruction

Behaviour:
- Reset (sync): fetch_pc=RESET_PC, state=S_REQ, discard=0, buffer empty, mem_req_o=0 during rst, pc_o=0, inst_o=NOP_INST, inst_valid_o=0. The first request is issued in the cycle after rst falls.
- States: S_REQ (request outstanding/issuing), S_FULL (buffer holds data, no request), S_DROP (waiting for the ack of an aborted request).
- S_REQ: mem_req_o=1, mem_addr_o=fetch_pc.
  - Ack, no redirect, stall_i=0: output regs <= {fetch_pc, rdata, valid=1} next edge; fetch_pc += 4 (mod 2^32); stay in S_REQ.
  - Ack, no redirect, stall_i=1: buffer <= {fetch_pc, rdata}; fetch_pc += 4; go to S_FULL.
  - No ack, stall_i=0: output becomes a bubble (inst_valid_o=0, inst_o=NOP_INST, pc_o holds).
- S_FULL: mem_req_o=0. When stall_i=0, buffer moves to the output regs, then state goes to S_REQ.
- Redirect (branch_enable_i=1):
  - Takes priority over stall_i and over any same-cycle ack; the acked data is dropped.
  - fetch_pc <= {branch_target_i[31:2], 2'b00}.
  - Buffer is cleared; output regs become the bubble next edge.
  - If a request is outstanding and not acked this cycle, go to S_DROP (address must not change mid-transaction); otherwise go to S_REQ.
- S_DROP: mem_req_o=1 holding the old address until ack; that ack's data is discarded, then go to S_REQ with the new fetch_pc. A further redirect in S_DROP only updates fetch_pc.
- Stall with no redirect: pc_o/inst_o/inst_valid_o hold their values exactly.
- Latency: ack at cycle t gives inst_o at t+1. Throughput is 1 inst/cycle with zero-wait memory.
- No instruction is ever duplicated or skipped on the sequential path.

Decomposition:
- Shared defines header holds: InstAddrBus/InstBus widths, ZeroWord, the NOP instruction constant and the fetch state encodings.
- One sub-module, if_hold_buf: 1-entry pc/inst holding register with load/clear/valid.
- FSM, PC arithmetic and output regs stay in if_fetch.

Test Plan:
- Reset, zero-wait ack every cycle, mem returns addr-tagged data → pc_o = 0,4,8,12 on consecutive cycles from cycle 2 after reset, inst_valid_o=1 throughout.
- Ack at pc=8 while stall_i=1 for 3 cycles → outputs frozen on pc=4; mem_req_o=0 during the stall; pc=8 appears the cycle after stall_i falls, then pc=12 is requested.
- 3-cycle ack latency; branch_enable_i=1 with target 0x100 in wait cycle 1 → mem_addr_o stays at the old address until ack; that data is never valid on the output; next mem_addr_o=0x100.
- branch_enable_i and mem_ack_i in the same cycle, target 0x203 → acked data dropped; mem_addr_o=0x200; inst_valid_o=0 next cycle.
- Redirect with stall_i=1 and buffer full → buffer cleared, inst_valid_o=0; first valid output has pc_o = target.
- fetch_pc=0xFFFF_FFFC, ack → next mem_addr_o=0x0000_0000; rst asserted mid-wait → next cycle all outputs at reset values, pending ack ignored.
